stopwatch_ctrl_fsm: RTL
=======================

// Module: stopwatch_ctrl_fsm
// PURPOSE
//  Sequencing controller for the stopwatch/timer counter datapath. Turns debounced user
//  buttons (start/stop, set, clear, mode) into counter controls. Raises the 2-bit user
//  error code consumed by the display/LED logic. Sits between the button debouncers and
//  the BCD counter; owns the mode register, run/pause state, error hold and idle timeout.
// PARAMETERS
//  ERR_HOLD    4   ticks the ERROR state is held before auto-return to PAUSE
//  ALARM_TICKS 10  ticks alarm stays high in DONE (timer expiry)
//  IDLE_TICKS  60  ticks with no button activity in IDLE before entering SLEEP
//  CNT_W       8   width of the internal tick counter (must hold max of the above)
// PORTS
//  clk       in  1  system clock
//  Reset     in  1  synchronous, active-high reset
//  tick      in  1  1-cycle 1 Hz enable from prescaler
//  start     in  1  1-cycle pulse, start/stop toggle
//  set       in  1  level, set-value mode held by user
//  clr_btn   in  1  1-cycle pulse, user clear
//  mode      in  1  0 = stopwatch (count up), 1 = timer (count down)
//  illegal   in  1  level from set-value checker, 1 = entered value out of range
//  at_zero   in  1  counter value == 0
//  cnt_en    out 1  counter advance enable
//  cnt_dir   out 1  0 = up, 1 = down (== registered mode_q)
//  cnt_load  out 1  1-cycle pulse: load set value into counter
//  cnt_clr   out 1  1-cycle pulse: clear counter
//  alarm     out 1  timer-expired indication
//  err_valid out 1  error code meaningful
//  err_code  out 2  0 illegal set, 1 mode change while running, 2 set+clear, 3 idle/sleep
//  state_o   out 3  current state encoding (debug/display)
// BEHAVIOUR
//  - States: IDLE=0 SET=1 RUN=2 PAUSE=3 ERROR=4 DONE=5 SLEEP=6; 7 unreachable -> IDLE.
//  - Reset (sync): state IDLE; mode_q=0; tick counter=0; all outputs 0.
//  - cnt_en = (state==RUN) & tick; cnt_dir = mode_q; alarm = (state==DONE);
//    err_valid = state in {ERROR, SLEEP}; err_code = 3 in SLEEP, else latched code.
//  - cnt_load / cnt_clr: registered, high exactly 1 cycle after the accepting edge.
//  - Global priority each cycle: Reset > (set & clr_btn -> ERROR, code 2) > per-state rules.
//  - IDLE: set -> SET. start -> RUN, except mode=1 & at_zero (stay, no action).
//    clr_btn -> cnt_clr. mode_q <= mode every cycle. IDLE_TICKS ticks with no start/set/clr -> SLEEP.
//  - SET: while set=1, stay. On set falling: illegal=0 -> cnt_load, PAUSE;
//    illegal=1 -> ERROR, code 0 (no load).
//  - RUN: start -> PAUSE. clr_btn -> cnt_clr, IDLE.
//    mode != mode_q -> ERROR, code 1 (counter frozen, mode_q unchanged).
//    mode_q=1 & at_zero & tick -> DONE (cnt_en suppressed that cycle). set is ignored.
//  - PAUSE: start -> RUN (same timer/at_zero exception as IDLE). set -> SET.
//    clr_btn -> cnt_clr, IDLE. mode_q <= mode.
//  - ERROR: inputs ignored except the global rules. After ERR_HOLD ticks -> PAUSE, code
//    cleared; code-2 entry also clears counter (cnt_clr) on exit and goes IDLE.
//  - DONE: start or clr_btn -> IDLE, with cnt_clr on clr. Else after ALARM_TICKS ticks -> IDLE.
//  - SLEEP: any of start/set/clr_btn -> IDLE. The waking press is consumed (no other action).
//  - Tick counter: cleared on every state change and on any button in IDLE.
//    Saturates at 2^CNT_W-1, no wrap.
//  - start and clr_btn in the same cycle: clr_btn wins.
// TESTING
//  1 Reset mid-RUN (mode=0): Reset=1 one cycle -> next cycle state_o=0, all outputs 0.
//  2 IDLE, start, 3 ticks, start -> cnt_en high on exactly 3 tick cycles; state_o=3.
//  3 PAUSE, set=1 (illegal=1), release set -> state_o=4, err_code=0, cnt_load never high.
//    After 4 ticks -> state_o=3.
//  4 RUN, toggle mode 0->1 -> next cycle state_o=4, err_code=1, cnt_dir stays 0.
//  5 mode=1 RUN, at_zero=1 with tick -> DONE, alarm=1 for 10 ticks, then state_o=0.
//  6 IDLE, 60 ticks no buttons -> state_o=6, err_code=3; set pulse -> state_o=0.
//    Also: set & clr_btn same cycle -> err_code=2.

Source files
------------

// File: rtl/stopwatch_ctrl_fsm_if.sv
// stopwatch_ctrl_fsm_if: button inputs and counter-control outputs of the stopwatch controller
interface stopwatch_ctrl_fsm_if;
  logic tick, start, set, clr_btn, mode, illegal, at_zero;
  logic cnt_en, cnt_dir, cnt_load, cnt_clr, alarm, err_valid;
  logic [1:0] err_code;
  logic [2:0] state_o;
  modport master (
    output tick, start, set, clr_btn, mode, illegal, at_zero,
    input  cnt_en, cnt_dir, cnt_load, cnt_clr, alarm, err_valid, err_code, state_o
  );
  modport slave (
    input  tick, start, set, clr_btn, mode, illegal, at_zero,
    output cnt_en, cnt_dir, cnt_load, cnt_clr, alarm, err_valid, err_code, state_o
  );
endinterface

// File: rtl/stopwatch_ctrl_fsm.sv
// stopwatch_ctrl_fsm: sequences debounced buttons into BCD counter controls, mode, alarm and error codes
module stopwatch_ctrl_fsm #(
  parameter int ERR_HOLD    = 4,
  parameter int ALARM_TICKS = 10,
  parameter int IDLE_TICKS  = 60,
  parameter int CNT_W       = 8
) (
  input logic                 clk,
  input logic                 Reset,
  stopwatch_ctrl_fsm_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, SET = 3'd1, RUN = 3'd2, PAUSE = 3'd3,
    ERROR = 3'd4, DONE = 3'd5, SLEEP = 3'd6, BAD = 3'd7
  } state_t;
  localparam logic [CNT_W-1:0] ERR_LAST   = CNT_W'(ERR_HOLD - 1);
  localparam logic [CNT_W-1:0] ALARM_LAST = CNT_W'(ALARM_TICKS - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_TICKS - 1);
  state_t state, state_n;
  logic mode_q, mode_n, load_q, load_n, clr_q, clr_n, cnt_rst;
  logic [1:0] code_q, code_n;
  logic [CNT_W-1:0] cnt;
  logic btn, blocked, mode_err, both;
  assign btn      = bus.start | bus.set | bus.clr_btn;
  assign blocked  = bus.mode & bus.at_zero;
  assign mode_err = bus.mode != mode_q;
  assign both     = bus.set & bus.clr_btn;
  assign bus.cnt_en    = (state == RUN) & bus.tick & ~mode_err & ~(mode_q & bus.at_zero);
  assign bus.cnt_dir   = mode_q;
  assign bus.cnt_load  = load_q;
  assign bus.cnt_clr   = clr_q;
  assign bus.alarm     = state == DONE;
  assign bus.err_valid = (state == ERROR) | (state == SLEEP);
  assign bus.err_code  = state == SLEEP ? 2'd3 : code_q;
  assign bus.state_o   = state;
  // next-state, latched error code and one-shot counter commands
  always_comb begin
    state_n = state;
    code_n  = code_q;
    load_n  = 1'b0;
    clr_n   = 1'b0;
    cnt_rst = both;
    mode_n  = (state == IDLE) | (state == PAUSE) ? bus.mode : mode_q;
    if (both) begin
      state_n = ERROR;
      code_n  = 2'd2;
    end else begin
      case (state)
        IDLE: begin
          cnt_rst = btn;
          if (bus.clr_btn) clr_n = 1'b1;
          else if (bus.set) state_n = SET;
          else if (bus.start & ~blocked) state_n = RUN;
          else if (~bus.start & bus.tick & (cnt >= IDLE_LAST)) state_n = SLEEP;
        end
        SET:
          if (~bus.set) begin
            state_n = bus.illegal ? ERROR : PAUSE;
            code_n  = bus.illegal ? 2'd0 : code_q;
            load_n  = ~bus.illegal;
          end
        RUN:
          if (bus.clr_btn) begin
            clr_n   = 1'b1;
            state_n = IDLE;
          end else if (mode_err) begin
            state_n = ERROR;
            code_n  = 2'd1;
          end else if (bus.start) state_n = PAUSE;
          else if (mode_q & bus.at_zero & bus.tick) state_n = DONE;
        PAUSE:
          if (bus.clr_btn) begin
            clr_n   = 1'b1;
            state_n = IDLE;
          end else if (bus.set) state_n = SET;
          else if (bus.start & ~blocked) state_n = RUN;
        ERROR:
          if (bus.tick & (cnt >= ERR_LAST)) begin
            state_n = code_q == 2'd2 ? IDLE : PAUSE;
            clr_n   = code_q == 2'd2;
            code_n  = 2'd0;
          end
        DONE:
          if (bus.clr_btn) begin
            clr_n   = 1'b1;
            state_n = IDLE;
          end else if (bus.start | (bus.tick & (cnt >= ALARM_LAST))) state_n = IDLE;
        SLEEP: state_n = btn ? IDLE : SLEEP;
        default: state_n = IDLE;
      endcase
    end
  end
  // state, mode, code, command pulses and saturating tick counter
  always_ff @(posedge clk) begin
    if (Reset) begin
      state  <= IDLE;
      mode_q <= 1'b0;
      code_q <= 2'd0;
      load_q <= 1'b0;
      clr_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      mode_q <= mode_n;
      code_q <= code_n;
      load_q <= load_n;
      clr_q  <= clr_n;
      cnt    <= (cnt_rst | (state_n != state)) ? '0 : (bus.tick & ~&cnt) ? cnt + 1'b1 : cnt;
    end
  end
endmodule
